reg_bank: RTL and testbench
===========================

# reg_bank

Parametrised bank of `DEPTH` general-purpose registers, each `WIDTH` bits wide. It generalises the single-bit load register to multi-bit words. Each word supports hold, load, increment and clear. One registered read port with a valid strobe sits alongside the write/op port. It is the building block for register files, counter arrays and the RAM8/RAM64 tiers in the memory hierarchy.

## Interface
Parameters:
- `WIDTH`, 16, bits per word
- `ADDR_W`, 3, address width; `DEPTH = 2**ADDR_W`
- `RST_VAL`, 0, value every word takes on reset (`WIDTH` bits)

Ports:
- `clk`  input  1  single clock; all state updates on rising edge
- `reset`  input  1  synchronous, active-high; one clock, reset synchronous active-high
- `op`  input  2  word operation: 00 HOLD, 01 LOAD, 10 INC, 11 CLR
- `waddr`  input  ADDR_W  target word of `op`
- `in`  input  WIDTH  data for LOAD
- `rd_en`  input  1  read request
- `raddr`  input  ADDR_W  read address
- `out`  output  WIDTH  registered read data
- `rvalid`  output  1  `out` holds the result of the read issued on the previous edge

## Operation
- Reset (sampled high at an edge):
  - all words become `RST_VAL`
  - `out` becomes 0 and `rvalid` becomes 0
  - `op` and `rd_en` presented in the same cycle are ignored
- Ops act only on word `waddr`. All other words hold.
  - HOLD: no change
  - LOAD: word ← `in`
  - INC: word ← word + 1, modulo 2^WIDTH. All-ones wraps to 0 with no carry flag.
  - CLR: word ← 0 (not `RST_VAL`)
- Read: when `rd_en`=1 at an edge:
  - `out` ← post-edge value of word `raddr`
  - `rvalid` ← 1
- Write-first bypass: if `rd_en`=1, `op`≠HOLD and `raddr`==`waddr` at the same edge, `out` returns the newly written value:
  - LOAD returns `in`
  - INC returns old+1
  - CLR returns 0
- When `rd_en`=0 at an edge: `rvalid` ← 0 and `out` holds its last value.
- No out-of-range addresses exist (`DEPTH` = 2**ADDR_W).
- Reset mid-stream: a read issued on the reset edge is dropped (`rvalid`=0 next cycle). An op issued on the reset edge has no effect.

## Timing
- Write/op latency: 1 edge. The new word value is visible to a read issued on that same edge, via the bypass.
- Read latency: 1 edge. `rd_en` at edge N gives `out`/`rvalid` valid after edge N, held until edge N+1.
- Throughput: one op and one read every cycle, fully independent.
- No combinational path from any input to `out` or `rvalid`.
- Reset values: every word = `RST_VAL`, `out` = 0, `rvalid` = 0.

## Structure
- Package `reg_bank_pkg`:
  - op encoding constants `OP_HOLD`, `OP_LOAD`, `OP_INC`, `OP_CLR`
  - a 2-bit `op_t` typedef
- Sub-module `reg_word`: one `WIDTH`-bit register.
  - Inputs: `clk`, `reset`, `sel`, `op`, `in`.
  - Output: `q`, plus a combinational `next_q` used for the bypass.
  - Reset value is `RST_VAL`.
  - `reg_bank` instantiates `DEPTH` of these in a generate loop.
  - Write decode is `sel = (waddr == i)`.
  - The read mux selects from `next_q` of word `raddr`.

## Test plan
- Reset with WIDTH=16, RST_VAL=16'h00A5: hold `reset` 1 cycle, then read addresses 0–7 back-to-back → each `out`=16'h00A5, `rvalid`=1 on each following cycle; during reset `out`=0, `rvalid`=0.
- LOAD/readback: LOAD 16'h1234 to addr 3 and 16'hBEEF to addr 5; read 3, 5, 4 → 16'h1234, 16'hBEEF, RST_VAL; no other word disturbed.
- INC wrap: LOAD 16'hFFFE to addr 7; INC twice; read after each → 16'hFFFF, then 16'h0000.
- Bypass: same edge LOAD 16'h0F0F to addr 2 with `rd_en`, raddr=2 → `out`=16'h0F0F next cycle; repeat with INC on that word → 16'h0F10; with CLR → 16'h0000.
- Independence: every cycle issue an op to addr k and a read of addr k+1 (k=0..6) → reads return pre-existing values unaffected by the concurrent op.
- Reset collision: assert `reset` on the same edge as LOAD 16'h5555 to addr 1 with `rd_en`=1 → `rvalid`=0 next cycle; the subsequent read of addr 1 returns RST_VAL.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank: word operation encoding.
// No logic; constants and types only.
// Imported by reg_word and reg_bank.
package reg_bank_pkg;

  // Per-word operation applied to the addressed word on a rising edge
  typedef logic [1:0] op_t;

  localparam op_t OP_HOLD = 2'b00;
  localparam op_t OP_LOAD = 2'b01;
  localparam op_t OP_INC  = 2'b10;
  localparam op_t OP_CLR  = 2'b11;

endpackage

// File: rtl/reg_word.sv
// One WIDTH-bit word supporting hold, load, increment and clear.
// Latency: 1 edge for q; next_q is the combinational post-edge value.
// No backpressure: an op is accepted on every edge where sel is high.
module reg_word
  import reg_bank_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  op_t              op,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] next_q
);

  logic [WIDTH-1:0] r_q;

  // Value the word will take on the next edge; exported for the read bypass.
  // Clear goes to zero rather than RST_VAL; increment wraps silently.
  always_comb begin
    next_q = r_q;
    if (sel) begin
      case (op)
        OP_LOAD: next_q = in;
        OP_INC:  next_q = r_q + WIDTH'(1);
        OP_CLR:  next_q = '0;
        default: next_q = r_q;
      endcase
    end
  end

  // Word storage with synchronous reset to RST_VAL
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= RST_VAL;
    end else begin
      r_q <= next_q;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/reg_bank.sv
// Bank of 2**ADDR_W words with one op port and one registered read port.
// Latency: op 1 edge; read 1 edge, with write-first bypass on address match.
// No backpressure: one op and one read accepted every cycle.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter int               ADDR_W  = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  op_t               op,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  in,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  out,
  output logic              rvalid
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] w_q    [DEPTH];
  logic [WIDTH-1:0] w_next [DEPTH];
  logic             w_bypass;
  logic [WIDTH-1:0] w_rd_dat;

  logic [WIDTH-1:0] r_out;
  logic             r_rvalid;

  // One word per address; only the word matching waddr sees the op
  for (genvar i = 0; i < DEPTH; i++) begin : g_word
    reg_word #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_word (
      .clk    (clk),
      .reset  (reset),
      .sel    (waddr == ADDR_W'(i)),
      .op     (op),
      .in     (in),
      .q      (w_q[i]),
      .next_q (w_next[i])
    );
  end

  // Post-edge value of word raddr: the freshly written value when the op
  // targets the same word, otherwise the stored value (which equals next_q).
  always_comb begin
    w_bypass = (op != OP_HOLD) && (raddr == waddr);
    w_rd_dat = w_bypass ? w_next[raddr] : w_q[raddr];
  end

  // Registered read port; out holds its last value when no read is issued
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out    <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= rd_en;
      if (rd_en) begin
        r_out <= w_rd_dat;
      end
    end
  end

  assign out    = r_out;
  assign rvalid = r_rvalid;

endmodule

// File: tb/tb_reg_bank.sv
module tb_reg_bank
  import reg_bank_pkg::*;
;

  localparam logic [15:0] RST_VAL = 16'h00A5;

  logic        clk = 1'b0;
  logic        reset;
  op_t         op;
  logic [2:0]  waddr;
  logic [15:0] in;
  logic        rd_en;
  logic [2:0]  raddr;
  logic [15:0] out;
  logic        rvalid;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic [15:0] m_mem [8];
  logic [15:0] m_out  = 16'h0000;
  logic        exp_vld = 1'b0;
  logic        mon_en  = 1'b0;
  logic [15:0] sb_q [$];
  logic [15:0] sb_e;

  reg_bank #(
    .WIDTH   (16),
    .ADDR_W  (3),
    .RST_VAL (RST_VAL)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .op     (op),
    .waddr  (waddr),
    .in     (in),
    .rd_en  (rd_en),
    .raddr  (raddr),
    .out    (out),
    .rvalid (rvalid)
  );

  always #5 clk = ~clk;

  // Drive one cycle, then advance the model to its post-edge state
  task automatic step(input logic rst, input op_t o, input logic [2:0] wa,
                      input logic [15:0] d, input logic re, input logic [2:0] ra);
    reset = rst; op = o; waddr = wa; in = d; rd_en = re; raddr = ra;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) m_mem[i] = RST_VAL;
      m_out   = 16'h0000;
      exp_vld = 1'b0;
    end else begin
      case (o)
        OP_LOAD: m_mem[wa] = d;
        OP_INC:  m_mem[wa] = m_mem[wa] + 16'd1;
        OP_CLR:  m_mem[wa] = 16'h0000;
        default: ;
      endcase
      exp_vld = re;
      if (re) begin
        sb_q.push_back(m_mem[ra]);
        m_out = m_mem[ra];
      end
    end
    mon_en = 1'b1;
    #1;
  endtask

  task automatic idle();
    step(1'b0, OP_HOLD, 3'd0, 16'h0000, 1'b0, 3'd0);
  endtask

  // Scoreboard: on each falling edge compare rvalid, and out against the
  // popped expectation (or the held value when no read completed)
  always @(negedge clk) begin
    if (mon_en) begin
      n_tests++;
      if (rvalid !== exp_vld) begin
        n_fail++;
        $display("FAIL sb_rvalid t=%0t got=%b exp=%b", $time, rvalid, exp_vld);
      end
      if (exp_vld) begin
        if (sb_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_underflow t=%0t", $time);
        end else begin
          sb_e = sb_q.pop_front();
          n_tests++;
          if (out !== sb_e) begin
            n_fail++;
            $display("FAIL sb_out t=%0t got=%h exp=%h", $time, out, sb_e);
          end
        end
      end else begin
        n_tests++;
        if (out !== m_out) begin
          n_fail++;
          $display("FAIL sb_out_hold t=%0t got=%h exp=%h", $time, out, m_out);
        end
      end
    end
  end

  task automatic test_reset();
    step(1'b1, OP_HOLD, 3'd0, 16'h0000, 1'b0, 3'd0);
    n_tests++;
    if (out !== 16'h0000 || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got out=%h rvalid=%b exp out=0000 rvalid=0", out, rvalid);
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, OP_HOLD, 3'd0, 16'h0000, 1'b1, 3'(i));
      n_tests++;
      if (out !== 16'h00A5) begin
        n_fail++;
        $display("FAIL reset_readback addr=%0d got=%h exp=00a5", i, out);
      end
    end
    idle();
  endtask

  task automatic test_load_readback();
    step(1'b0, OP_LOAD, 3'd3, 16'h1234, 1'b0, 3'd0);
    step(1'b0, OP_LOAD, 3'd5, 16'hBEEF, 1'b0, 3'd0);
    step(1'b0, OP_HOLD, 3'd0, 16'h0000, 1'b1, 3'd3);
    step(1'b0, OP_HOLD, 3'd0, 16'h0000, 1'b1, 3'd5);
    n_tests++;
    if (out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL load_addr5 got=%h exp=beef", out);
    end
    step(1'b0, OP_HOLD, 3'd0, 16'h0000, 1'b1, 3'd4);
    idle();
    n_tests++;
    if (out !== 16'h00A5 || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL load_hold got out=%h rvalid=%b exp out=00a5 rvalid=0", out, rvalid);
    end
    for (int i = 0; i < 8; i++) step(1'b0, OP_HOLD, 3'd0, 16'h0000, 1'b1, 3'(i));
    idle();
  endtask

  task automatic test_inc_wrap();
    step(1'b0, OP_LOAD, 3'd7, 16'hFFFE, 1'b0, 3'd0);
    step(1'b0, OP_INC,  3'd7, 16'h0000, 1'b0, 3'd0);
    step(1'b0, OP_HOLD, 3'd0, 16'h0000, 1'b1, 3'd7);
    n_tests++;
    if (out !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL inc_first got=%h exp=ffff", out);
    end
    step(1'b0, OP_INC,  3'd7, 16'h0000, 1'b0, 3'd0);
    step(1'b0, OP_HOLD, 3'd0, 16'h0000, 1'b1, 3'd7);
    n_tests++;
    if (out !== 16'h0000) begin
      n_fail++;
      $display("FAIL inc_wrap got=%h exp=0000", out);
    end
    idle();
  endtask

  task automatic test_bypass();
    step(1'b0, OP_LOAD, 3'd2, 16'h0F0F, 1'b1, 3'd2);
    n_tests++;
    if (out !== 16'h0F0F) begin
      n_fail++;
      $display("FAIL bypass_load got=%h exp=0f0f", out);
    end
    step(1'b0, OP_INC, 3'd2, 16'h0000, 1'b1, 3'd2);
    n_tests++;
    if (out !== 16'h0F10) begin
      n_fail++;
      $display("FAIL bypass_inc got=%h exp=0f10", out);
    end
    step(1'b0, OP_CLR, 3'd2, 16'h0000, 1'b1, 3'd2);
    n_tests++;
    if (out !== 16'h0000) begin
      n_fail++;
      $display("FAIL bypass_clr got=%h exp=0000", out);
    end
    idle();
  endtask

  task automatic test_independence();
    op_t o;
    for (int k = 0; k < 8; k++) step(1'b0, OP_LOAD, 3'(k), 16'h1000 + 16'(k), 1'b0, 3'd0);
    for (int k = 0; k < 7; k++) begin
      o = (k % 3 == 0) ? OP_LOAD : ((k % 3 == 1) ? OP_INC : OP_CLR);
      step(1'b0, o, 3'(k), 16'hA000 + 16'(k), 1'b1, 3'(k + 1));
      n_tests++;
      if (out !== 16'h1000 + 16'(k + 1)) begin
        n_fail++;
        $display("FAIL indep k=%0d got=%h exp=%h", k, out, 16'h1000 + 16'(k + 1));
      end
    end
    for (int i = 0; i < 8; i++) step(1'b0, OP_HOLD, 3'd0, 16'h0000, 1'b1, 3'(i));
    idle();
  endtask

  task automatic test_reset_collision();
    step(1'b0, OP_LOAD, 3'd1, 16'h1111, 1'b0, 3'd0);
    step(1'b1, OP_LOAD, 3'd1, 16'h5555, 1'b1, 3'd1);
    n_tests++;
    if (rvalid !== 1'b0 || out !== 16'h0000) begin
      n_fail++;
      $display("FAIL collision_drop got out=%h rvalid=%b exp out=0000 rvalid=0", out, rvalid);
    end
    step(1'b0, OP_HOLD, 3'd0, 16'h0000, 1'b1, 3'd1);
    n_tests++;
    if (out !== 16'h00A5) begin
      n_fail++;
      $display("FAIL collision_readback got=%h exp=00a5", out);
    end
    idle();
  endtask

  initial begin
    reset = 1'b1; op = OP_HOLD; waddr = '0; in = '0; rd_en = 1'b0; raddr = '0;
    for (int i = 0; i < 8; i++) m_mem[i] = RST_VAL;
    test_reset();
    test_load_readback();
    test_inc_wrap();
    test_bypass();
    test_independence();
    test_reset_collision();
    @(negedge clk);
    #1;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover got=%0d exp=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
